// File: rtl/struct_array_change_monitor.sv
// Register file of DEPTH {x} entries; each value-changing write queues {idx, old, new} in a FIFO
// drained by a valid/ready consumer. Optional macro STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN adds ev_tstamp.
module struct_array_change_monitor #(
    parameter int DEPTH      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [31:0]                   wr_data,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [31:0]                   rd_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [IDX_W-1:0]              ev_idx,
    output logic [31:0]                   ev_old,
    output logic [31:0]                   ev_new,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          ev_overflow
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
    ,
    output logic [31:0]                   ev_tstamp
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct {
        logic [31:0] x;
    } entry_t;

    entry_t entries [DEPTH];

    logic             wr_hit;
    logic [31:0]      old_val;
    logic [31:0]      rd_val;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             ovf_q;

    logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
    logic [31:0]      q_old [FIFO_DEPTH];
    logic [31:0]      q_new [FIFO_DEPTH];

    // Last popped head, shown while the FIFO is empty so head fields stay stable.
    logic [IDX_W-1:0] hold_idx;
    logic [31:0]      hold_old;
    logic [31:0]      hold_new;

    // Index decode by comparison keeps out-of-range indices from ever touching storage.
    always_comb begin
        wr_hit  = 1'b0;
        old_val = '0;
        rd_val  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_hit  = 1'b1;
                old_val = entries[i].x;
            end
            if (rd_idx == IDX_W'(i)) begin
                rd_val = entries[i].x;
            end
        end
    end

    assign rd_data = rd_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].x <= '0;
            end
        end else if (wr_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    entries[i].x <= wr_data;
                end
            end
        end
    end

    // Handshake: the head transfers on any edge where ev_valid && ev_ready; ev_valid
    // never depends on ev_ready, and a full FIFO accepts a push only alongside a pop.
    always_comb begin
        push    = wr_valid && wr_hit && (wr_data != old_val);
        pop     = (count_q != '0) && ev_ready;
        full    = (count_q == FULL_CNT);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        count_next = count_q;
        case ({push_ok, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            hold_idx <= '0;
            hold_old <= '0;
            hold_new <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_idx[i] <= '0;
                q_old[i] <= '0;
                q_new[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                q_idx[wr_ptr] <= wr_idx;
                q_old[wr_ptr] <= old_val;
                q_new[wr_ptr] <= wr_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                hold_idx <= q_idx[rd_ptr];
                hold_old <= q_old[rd_ptr];
                hold_new <= q_new[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            count_q <= count_next;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ev_valid    = (count_q != '0);
    assign ev_count    = count_q;
    assign ev_overflow = ovf_q;
    assign ev_idx      = ev_valid ? q_idx[rd_ptr] : hold_idx;
    assign ev_old      = ev_valid ? q_old[rd_ptr] : hold_old;
    assign ev_new      = ev_valid ? q_new[rd_ptr] : hold_new;

`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] q_ts [FIFO_DEPTH];
    logic [31:0] hold_ts;

    // Free-running cycle counter; the value at the push edge is stored with the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            hold_ts <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_ts[i] <= '0;
            end
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (push_ok) begin
                q_ts[wr_ptr] <= cycle_q;
            end
            if (pop) begin
                hold_ts <= q_ts[rd_ptr];
            end
        end
    end

    assign ev_tstamp = ev_valid ? q_ts[rd_ptr] : hold_ts;
`endif

endmodule

// File: tb/tb_struct_array_change_monitor.sv
// Randomized bench for struct_array_change_monitor against a queue-based reference model.
module tb_struct_array_change_monitor;

    localparam int DEPTH      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int EV_W       = IDX_W + 64;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       wr_data;
    logic [IDX_W-1:0]  rd_idx;
    logic [31:0]       rd_data;
    logic              ev_valid;
    logic              ev_ready;
    logic [IDX_W-1:0]  ev_idx;
    logic [31:0]       ev_old;
    logic [31:0]       ev_new;
    logic [CNT_W-1:0]  ev_count;
    logic              ev_overflow;
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
    logic [31:0]       ev_tstamp;
    logic [31:0]       tb_cyc;
    logic [31:0]       ts_q[$];
    logic [31:0]       last_ts;
`endif

    int n_checks;
    int n_errors;

    // Reference model: entry values, pending events {idx,old,new}, last popped event, overflow flag.
    logic [31:0]       model_mem [DEPTH];
    logic [EV_W-1:0]   exp_q[$];
    logic [EV_W-1:0]   last_pop;
    logic              model_ovf;

    struct_array_change_monitor #(
        .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_idx(ev_idx), .ev_old(ev_old), .ev_new(ev_new),
        .ev_count(ev_count), .ev_overflow(ev_overflow)
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
        , .ev_tstamp(ev_tstamp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
        last_pop  = '0;
        model_ovf = 1'b0;
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
        ts_q.delete();
        last_ts = '0;
`endif
    endtask

    task automatic check_outputs(input logic [IDX_W-1:0] ri);
        logic [EV_W-1:0] h;
        logic [31:0]     exp_rd;
        h      = (exp_q.size() != 0) ? exp_q[0] : last_pop;
        exp_rd = (int'(ri) < DEPTH) ? model_mem[int'(ri)] : 32'd0;
        check("ev_count", 64'(ev_count), 64'(exp_q.size()));
        check("ev_valid", 64'(ev_valid), 64'(exp_q.size() != 0));
        check("ev_overflow", 64'(ev_overflow), 64'(model_ovf));
        check("rd_data", 64'(rd_data), 64'(exp_rd));
        check("ev_idx", 64'(ev_idx), 64'(h[EV_W-1:64]));
        check("ev_old", 64'(ev_old), 64'(h[63:32]));
        check("ev_new", 64'(ev_new), 64'(h[31:0]));
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
        check("ev_tstamp", 64'(ev_tstamp), 64'((ts_q.size() != 0) ? ts_q[0] : last_ts));
`endif
    endtask

    // One clock: drive at negedge, advance the model by the rules, sample 1ns after posedge.
    task automatic step(input logic wv, input logic [IDX_W-1:0] wi, input logic [31:0] wd,
                        input logic rdy, input logic [IDX_W-1:0] ri);
        @(negedge clk);
        wr_valid = wv;
        wr_idx   = wi;
        wr_data  = wd;
        ev_ready = rdy;
        rd_idx   = ri;
        if (rdy && exp_q.size() != 0) begin
            last_pop = exp_q.pop_front();
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
            last_ts = ts_q.pop_front();
`endif
        end
        if (wv && int'(wi) < DEPTH) begin
            if (model_mem[int'(wi)] != wd) begin
                if (exp_q.size() < FIFO_DEPTH) begin
                    exp_q.push_back({wi, model_mem[int'(wi)], wd});
`ifdef STRUCT_ARRAY_CHANGE_MONITOR_TSTAMP_EN
                    ts_q.push_back(tb_cyc);
`endif
                end else begin
                    model_ovf = 1'b1;
                end
            end
            model_mem[int'(wi)] = wd;
        end
        @(posedge clk);
        #1;
        check_outputs(ri);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        ev_ready = 1'b0;
        model_clear();
        #1;
        check("rst_ev_valid", 64'(ev_valid), 64'd0);
        check("rst_ev_count", 64'(ev_count), 64'd0);
        check("rst_ev_overflow", 64'(ev_overflow), 64'd0);
        check("rst_ev_head", {ev_old, ev_new}, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            check("rst_rd_data", 64'(rd_data), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        ev_ready = 1'b0;
        rd_idx   = '0;
        model_clear();
        apply_reset();

        // Same-value write produces nothing; two real changes peak the count at 2.
        step(1'b1, 4'd1, 32'd5, 1'b0, 4'd1);
        step(1'b1, 4'd1, 32'd5, 1'b0, 4'd1);
        step(1'b1, 4'd1, 32'd0, 1'b0, 4'd1);
        check("peak_count", 64'(ev_count), 64'd2);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd1);

        // Fill, then push with a simultaneous pop, then overflow with a blocked consumer.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, IDX_W'(i), 32'(i + 1), 1'b0, IDX_W'(i));
        step(1'b1, 4'd2, 32'd7, 1'b1, 4'd2);
        check("full_pop_push_count", 64'(ev_count), 64'd4);
        check("full_pop_push_ovf", 64'(ev_overflow), 64'd0);
        step(1'b1, 4'd0, 32'd9, 1'b0, 4'd0);
        check("overflow_sticky", 64'(ev_overflow), 64'd1);
        check("rd_after_drop", 64'(rd_data), 64'd9);

        // Out-of-range write and read.
        step(1'b1, 4'd5, 32'd123, 1'b0, 4'd5);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 32'd0, 1'b1, IDX_W'(i));

        // Asynchronous reset with events pending, then confirm nothing appears for the clearing.
        for (int i = 0; i < 3; i++) step(1'b1, IDX_W'(i), 32'(i + 10), 1'b0, 4'd0);
        apply_reset();
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3);

        // Random traffic; small data range forces frequent same-value writes.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), IDX_W'($urandom_range(0, 5)),
                 32'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                 IDX_W'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
